// File: rtl/fuzzy_sweep_seq.sv
// rtl/fuzzy_sweep_seq.sv - 2-D input sweep sequencer for Fuzzy_1 surface extraction
// Steps Entrada_01/02 over a clamped grid, settles, then streams saida_defuzzy samples.
module fuzzy_sweep_seq #(
  parameter int unsigned STEP       = 1,
  parameter int unsigned SETTLE_CYC = 14,
  parameter logic [7:0]  MIN_VAL    = 8'd1,
  parameter logic [7:0]  MAX_VAL    = 8'd254
) (
  input  logic        clk_0,
  input  logic        Srst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  Entrada_01,
  output logic [7:0]  Entrada_02,
  input  logic [7:0]  saida_defuzzy,
  output logic [7:0]  res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_last,
  output logic [16:0] pt_cnt,
  output logic        busy,
  output logic        done
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [10:0]   STEP_W   = 11'(STEP);
  localparam logic [10:0]   GRID_MAX = 11'd256;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    i_q, i_d, j_q, j_d;
  logic [7:0]    e1_q, e1_d, e2_q, e2_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, last_q, last_d;
  logic [16:0]   pt_q, pt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   i_step, j_step;
  logic          i_end, j_end;

  function automatic logic [7:0] clamp(input logic [9:0] v);
    if (v < {2'b00, MIN_VAL}) return MIN_VAL;
    if (v > {2'b00, MAX_VAL}) return MAX_VAL;
    return v[7:0];
  endfunction

  // 11-bit sums so the "past 256" test never wraps for any legal STEP.
  assign i_step = {1'b0, i_q} + STEP_W;
  assign j_step = {1'b0, j_q} + STEP_W;
  assign i_end  = i_step > GRID_MAX;
  assign j_end  = j_step > GRID_MAX;

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      e1_q    <= MIN_VAL;
      e2_q    <= MIN_VAL;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    pt_d    = pt_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_SETTLE;
            i_d     = '0;
            j_d     = '0;
            e1_d    = clamp(10'd0);
            e2_d    = clamp(10'd0);
            pt_d    = '0;
            cnt_d   = CNT_LOAD;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            data_d  = saida_defuzzy;
            valid_d = 1'b1;
            last_d  = i_end && j_end;
            state_d = S_EMIT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_EMIT: begin
          if (valid_q && res_ready) begin
            valid_d = 1'b0;
            pt_d    = pt_q + 17'd1;
            if (last_q) begin
              state_d = S_DONE;
            end else begin
              if (!j_end) begin
                j_d = j_step[9:0];
              end else begin
                j_d = '0;
                i_d = i_step[9:0];
              end
              e1_d    = clamp(i_d);
              e2_d    = clamp(j_d);
              cnt_d   = CNT_LOAD;
              state_d = S_SETTLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Entrada_01 = e1_q;
  assign Entrada_02 = e2_q;
  assign res_data   = data_q;
  assign res_valid  = valid_q;
  assign res_last   = last_q;
  assign pt_cnt     = pt_q;
  assign busy       = (state_q == S_SETTLE) || (state_q == S_EMIT);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_fuzzy_sweep_seq.sv
// tb/tb_fuzzy_sweep_seq.sv - self-checking bench for fuzzy_sweep_seq
// Point-indexed reference model plus directed grid, backpressure, abort and reset scenarios.
module tb_fuzzy_sweep_seq;

  localparam int STEP = 64;
  localparam int SC   = 3;
  localparam int N    = 256 / STEP + 1;
  localparam int NPTS = N * N;

  logic        clk_0 = 1'b0;
  logic        Srst  = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  saida_defuzzy = 8'd0;
  logic        res_ready = 1'b0;
  logic [7:0]  Entrada_01, Entrada_02, res_data;
  logic        res_valid, res_last, busy, done;
  logic [16:0] pt_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  fuzzy_sweep_seq #(.STEP(STEP), .SETTLE_CYC(SC), .MIN_VAL(8'd1), .MAX_VAL(8'd254)) dut (
    .clk_0(clk_0), .Srst(Srst), .start(start), .abort(abort),
    .Entrada_01(Entrada_01), .Entrada_02(Entrada_02), .saida_defuzzy(saida_defuzzy),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
    .pt_cnt(pt_cnt), .busy(busy), .done(done)
  );

  always #5 clk_0 = ~clk_0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_clamp(input int v);
    if (v < 1) return 8'd1;
    if (v > 254) return 8'd254;
    return 8'(v);
  endfunction

  // Reference: point k sits at (k/N, k%N) on the grid; sampled SC edges after it is applied.
  bit          m_active, m_pend, m_done, m_last;
  int          m_k, m_wait, m_cnt;
  logic [7:0]  m_e1, m_e2, m_data;

  always @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      m_active <= 0; m_pend <= 0; m_done <= 0; m_last <= 0;
      m_k <= 0; m_wait <= 0; m_cnt <= 0;
      m_e1 <= 8'd1; m_e2 <= 8'd1; m_data <= 8'd0;
    end else if (abort) begin
      m_active <= 0; m_pend <= 0; m_done <= 0; m_last <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1; m_done <= 0; m_k <= 0; m_wait <= SC; m_cnt <= 0;
        m_e1 <= ref_clamp(0); m_e2 <= ref_clamp(0);
      end
    end else if (!m_pend) begin
      if (m_wait == 1) begin
        m_pend <= 1; m_data <= saida_defuzzy; m_last <= (m_k == NPTS - 1);
      end else begin
        m_wait <= m_wait - 1;
      end
    end else if (res_ready) begin
      m_pend <= 0;
      m_cnt  <= m_cnt + 1;
      if (m_k == NPTS - 1) begin
        m_active <= 0; m_done <= 1;
      end else begin
        m_k    <= m_k + 1;
        m_wait <= SC;
        m_e1   <= ref_clamp(((m_k + 1) / N) * STEP);
        m_e2   <= ref_clamp(((m_k + 1) % N) * STEP);
      end
    end
  end

  always @(negedge clk_0) begin
    if (cmp_en && !Srst) begin
      chk("m_e1", Entrada_01, m_e1);
      chk("m_e2", Entrada_02, m_e2);
      chk("m_valid", res_valid, m_pend);
      chk("m_busy", busy, m_active);
      chk("m_done", done, m_done);
      chk("m_pt_cnt", pt_cnt, m_cnt);
      if (m_pend) begin
        chk("m_data", res_data, m_data);
        chk("m_last", res_last, m_last);
      end
    end
  end

  task automatic wait_valid(input string nm);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk_0);
      if (res_valid) return;
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  logic [7:0] axis [N] = '{8'd1, 8'd64, 8'd128, 8'd192, 8'd254};
  logic [7:0] rec_e1 [NPTS];
  logic [7:0] rec_e2 [NPTS];
  logic       rec_last [NPTS];
  int nres, nlast, lat;
  logic [7:0] h_data, h_e1, h_e2;
  logic       h_last;

  initial begin
    repeat (2) @(negedge clk_0);
    Srst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk_0); #1;
    chk("rst_e1", Entrada_01, 1);
    chk("rst_e2", Entrada_02, 1);
    chk("rst_data", res_data, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_pt_cnt", pt_cnt, 0);
    chk("rst_busy_done", {busy, done}, 0);

    // Fixed sample and full sweep with consumer always ready
    @(negedge clk_0);
    start = 1; saida_defuzzy = 8'hA5; res_ready = 1;
    @(posedge clk_0); #1;
    start = 0;
    lat = 0;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk_0); #1;
      if (res_valid) begin lat = t; break; end
    end
    chk("first_latency", lat, 3);
    chk("first_data", res_data, 8'hA5);
    nres = 0;
    rec_e1[0] = Entrada_01; rec_e2[0] = Entrada_02; rec_last[0] = res_last;
    nres = 1;
    for (int t = 0; t < 400 && !done; t++) begin
      saida_defuzzy = 8'($urandom);
      @(posedge clk_0); #1;
      if (res_valid && nres < NPTS) begin
        rec_e1[nres] = Entrada_01; rec_e2[nres] = Entrada_02; rec_last[nres] = res_last;
        nres++;
      end
    end
    chk("sweep_points", nres, NPTS);
    chk("sweep_pt_cnt", pt_cnt, 25);
    chk("sweep_done", done, 1);
    nlast = 0;
    for (int k = 0; k < nres; k++) begin
      chk("grid_e1", rec_e1[k], axis[k / N]);
      chk("grid_e2", rec_e2[k], axis[k % N]);
      if (rec_last[k]) nlast++;
    end
    chk("last_count", nlast, 1);
    chk("last_on_final", rec_last[NPTS-1], 1);

    // Restart from DONE with backpressure on point 2
    @(negedge clk_0);
    start = 1; res_ready = 0;
    @(negedge clk_0);
    start = 0;
    wait_valid("bp_p1");
    res_ready = 1;
    @(negedge clk_0);
    res_ready = 0;
    wait_valid("bp_p2");
    h_data = res_data; h_last = res_last; h_e1 = Entrada_01; h_e2 = Entrada_02;
    chk("bp_e2_lit", h_e2, 64);
    repeat (20) begin
      @(negedge clk_0);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, h_data);
      chk("bp_last", res_last, h_last);
      chk("bp_inputs", {Entrada_01, Entrada_02}, {h_e1, h_e2});
    end
    res_ready = 1;
    @(posedge clk_0); #1;
    chk("bp_next_e2", Entrada_02, 128);
    chk("bp_accept_valid", res_valid, 0);
    chk("bp_accept_cnt", pt_cnt, 2);

    // Abort on the accept edge of point 7
    lat = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk_0);
      if (res_valid && pt_cnt == 6) begin lat = 1; break; end
    end
    chk("abort_reach_p7", lat, 1);
    abort = 1;
    @(posedge clk_0); #1;
    chk("abort_valid", res_valid, 0);
    chk("abort_pt_cnt", pt_cnt, 6);
    chk("abort_busy_done", {busy, done}, 0);
    chk("abort_hold_e", {Entrada_01, Entrada_02}, {8'd64, 8'd64});
    @(negedge clk_0);
    abort = 0; start = 1;
    @(posedge clk_0); #1;
    chk("restart_pt_cnt", pt_cnt, 0);
    chk("restart_e", {Entrada_01, Entrada_02}, {8'd1, 8'd1});
    chk("restart_busy", busy, 1);

    // Asynchronous reset mid-SETTLE
    @(negedge clk_0);
    start = 0;
    #2 Srst = 1;
    #1;
    chk("srst_e", {Entrada_01, Entrada_02}, {8'd1, 8'd1});
    chk("srst_busy", busy, 0);
    chk("srst_pt_cnt", pt_cnt, 0);
    #1 Srst = 0;

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_0);
      saida_defuzzy = 8'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk_0);
    start = 0; abort = 0;
    @(negedge clk_0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
